// File: rtl/mmult_tcdm_rr_arbiter.sv
// Merges MP upstream TCDM master ports onto one downstream TCDM port with
// round-robin selection; responses are steered back through an in-order ID FIFO.
module mmult_tcdm_rr_arbiter #(
  parameter int MP    = 3,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [MP-1:0]               s_req,
  output logic [MP-1:0]               s_gnt,
  input  logic [MP-1:0][AW-1:0]       s_add,
  input  logic [MP-1:0]               s_wen,
  input  logic [MP-1:0][DW/8-1:0]     s_be,
  input  logic [MP-1:0][DW-1:0]       s_data,
  output logic [MP-1:0][DW-1:0]       s_r_data,
  output logic [MP-1:0]               s_r_valid,
  output logic                        m_req,
  input  logic                        m_gnt,
  output logic [AW-1:0]               m_add,
  output logic                        m_wen,
  output logic [DW/8-1:0]             m_be,
  output logic [DW-1:0]               m_data,
  input  logic [DW-1:0]               m_r_data,
  input  logic                        m_r_valid,
  output logic [$clog2(DEPTH+1)-1:0]  outst_o,
  output logic                        err_o
);

  localparam int IW = (MP > 1) ? $clog2(MP) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] sel;
  logic [IW-1:0] fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [IW-1:0] head;
  logic          err;
  logic          any_req;
  logic          fifo_full;
  logic          hs;
  logic          pop;

  // Scan downward over the offsets so the smallest offset from rr_ptr wins.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    int idx;
    idx = 0;
    sel = rr_ptr;
    for (int k = MP - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= MP) idx = idx - MP;
      if (s_req[idx]) sel = IW'(idx);
    end
  end

  assign any_req   = |s_req;
  assign fifo_full = (count == CW'(DEPTH));
  // Full check uses the registered count, so a same-cycle pop never frees a slot early.
  assign m_req     = ~rst_i & any_req & ~fifo_full;
  assign hs        = m_req & m_gnt;
  assign head      = fifo_mem[rd_ptr];
  assign pop       = ~rst_i & m_r_valid & (count != '0);
  assign outst_o   = count;
  assign err_o     = err;

  always_comb begin
    m_add     = '0;
    m_wen     = 1'b0;
    m_be      = '0;
    m_data    = '0;
    s_gnt     = '0;
    s_r_valid = '0;
    if (m_req) begin
      m_add  = s_add[sel];
      m_wen  = s_wen[sel];
      m_be   = s_be[sel];
      m_data = s_data[sel];
    end
    if (hs)  s_gnt[sel]      = 1'b1;
    if (pop) s_r_valid[head] = 1'b1;
    for (int i = 0; i < MP; i++) s_r_data[i] = m_r_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (hs) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        rr_ptr <= (sel == IW'(MP - 1)) ? '0 : sel + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (hs && !pop)      count <= count + 1'b1;
      else if (!hs && pop) count <= count - 1'b1;
      // A response with nothing outstanding is dropped and flagged until reset.
      if (m_r_valid && (count == '0)) err <= 1'b1;
    end
  end

  // NOTE: the ID storage is deliberately not reset; the pointers and count
  // define which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (hs) fifo_mem[wr_ptr] <= sel;
  end

endmodule

// File: tb/tb_mmult_tcdm_rr_arbiter.sv
// Directed bench for mmult_tcdm_rr_arbiter (MP=3, DEPTH=2) with hand-computed
// expectations for grant order, response routing, backpressure and error flag.
module tb_mmult_tcdm_rr_arbiter;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [2:0]        s_req;
  logic [2:0]        s_gnt;
  logic [2:0][31:0]  s_add;
  logic [2:0]        s_wen;
  logic [2:0][3:0]   s_be;
  logic [2:0][31:0]  s_data;
  logic [2:0][31:0]  s_r_data;
  logic [2:0]        s_r_valid;
  logic              m_req;
  logic              m_gnt;
  logic [31:0]       m_add;
  logic              m_wen;
  logic [3:0]        m_be;
  logic [31:0]       m_data;
  logic [31:0]       m_r_data;
  logic              m_r_valid;
  logic [1:0]        outst_o;
  logic              err_o;

  int n_checks = 0;
  int n_fail   = 0;

  mmult_tcdm_rr_arbiter #(.MP(3), .AW(32), .DW(32), .DEPTH(2)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_req     (s_req),
    .s_gnt     (s_gnt),
    .s_add     (s_add),
    .s_wen     (s_wen),
    .s_be      (s_be),
    .s_data    (s_data),
    .s_r_data  (s_r_data),
    .s_r_valid (s_r_valid),
    .m_req     (m_req),
    .m_gnt     (m_gnt),
    .m_add     (m_add),
    .m_wen     (m_wen),
    .m_be      (m_be),
    .m_data    (m_data),
    .m_r_data  (m_r_data),
    .m_r_valid (m_r_valid),
    .outst_o   (outst_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    s_req     = '0;
    m_gnt     = 1'b0;
    m_r_valid = 1'b0;
    m_r_data  = '0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      s_add[i]  = 32'h100 * (i + 1);
      s_data[i] = 32'hAA00 + i;
      s_be[i]   = 4'h1 << i;
      s_wen[i]  = (i != 1);
    end

    // Reset state, with requests and grant active during reset.
    do_reset();
    rst_i = 1'b1;
    s_req = 3'b111;
    m_gnt = 1'b1;
    #1;
    check("rst_m_req", m_req, 0);
    check("rst_m_add", m_add, 0);
    check("rst_s_gnt", s_gnt, 0);
    check("rst_s_r_valid", s_r_valid, 0);
    check("rst_outst", outst_o, 0);
    check("rst_err", err_o, 0);
    do_reset();

    // Single read from port 1.
    s_add[1] = 32'h1000;
    s_wen[1] = 1'b1;
    s_req    = 3'b010;
    m_gnt    = 1'b1;
    #1;
    check("sr_gnt", s_gnt, 3'b010);
    check("sr_m_add", m_add, 32'h1000);
    check("sr_m_wen", m_wen, 1);
    check("sr_outst0", outst_o, 0);
    tick();
    s_req     = 3'b000;
    m_r_valid = 1'b1;
    m_r_data  = 32'hCAFE0001;
    #1;
    check("sr_outst1", outst_o, 1);
    check("sr_rvalid", s_r_valid, 3'b010);
    check("sr_rdata", s_r_data[1], 32'hCAFE0001);
    tick();
    m_r_valid = 1'b0;
    #1;
    check("sr_outst2", outst_o, 0);
    s_add[1] = 32'h200;
    s_wen[1] = 1'b0;

    // Round-robin with all ports requesting and one-cycle response latency.
    do_reset();
    s_req = 3'b111;
    m_gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      m_r_valid = (k > 0);
      m_r_data  = 32'hD0000000 + 32'(k - 1);
      #1;
      check("rr_gnt", s_gnt, 3'b001 << (k % 3));
      check("rr_add", m_add, 32'h100 * ((k % 3) + 1));
      check("rr_data", m_data, 32'hAA00 + (k % 3));
      check("rr_be", m_be, 4'h1 << (k % 3));
      if (k > 0) begin
        check("rr_rvalid", s_r_valid, 3'b001 << ((k - 1) % 3));
        check("rr_rdata", s_r_data[(k - 1) % 3], 32'hD0000000 + 32'(k - 1));
        check("rr_outst", outst_o, 1);
      end
      tick();
    end
    s_req     = 3'b000;
    m_r_valid = 1'b1;
    m_r_data  = 32'hD0000005;
    #1;
    check("rr_last_rvalid", s_r_valid, 3'b100);
    check("rr_last_rdata", s_r_data[2], 32'hD0000005);
    check("rr_idle_m_req", m_req, 0);
    tick();
    m_r_valid = 1'b0;
    check("rr_outst_end", outst_o, 0);

    // Backpressure at DEPTH=2, then push/pop at full.
    do_reset();
    s_req = 3'b101;
    m_gnt = 1'b1;
    #1;
    check("bp_gnt0", s_gnt, 3'b001);
    tick();
    check("bp_gnt1", s_gnt, 3'b100);
    tick();
    check("bp_outst_full", outst_o, 2);
    check("bp_m_req_full", m_req, 0);
    check("bp_gnt_full", s_gnt, 3'b000);
    m_r_valid = 1'b1;
    m_r_data  = 32'h12345678;
    #1;
    check("bp_pop_rvalid", s_r_valid, 3'b001);
    check("bp_pop_no_gnt", s_gnt, 3'b000);
    tick();
    m_r_valid = 1'b0;
    check("bp_outst_after_pop", outst_o, 1);
    check("bp_gnt_after_pop", s_gnt, 3'b001);
    tick();
    s_req = 3'b000;
    check("bp_outst_refill", outst_o, 2);
    m_r_valid = 1'b1;
    #1;
    check("bp_drain_a", s_r_valid, 3'b100);
    tick();
    check("bp_drain_b", s_r_valid, 3'b001);
    tick();
    m_r_valid = 1'b0;
    check("bp_outst_drained", outst_o, 0);
    check("bp_err", err_o, 0);

    // Downstream stall: pointer sits at port 2 and must not move.
    do_reset();
    s_req = 3'b010;
    m_gnt = 1'b1;
    #1;
    check("st_pre_gnt", s_gnt, 3'b010);
    tick();
    s_req     = 3'b000;
    m_r_valid = 1'b1;
    tick();
    m_r_valid = 1'b0;
    s_req     = 3'b111;
    m_gnt     = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("st_gnt", s_gnt, 3'b000);
      check("st_sel_add", m_add, 32'h300);
      tick();
    end
    m_gnt = 1'b1;
    #1;
    check("st_first_gnt", s_gnt, 3'b100);
    tick();
    s_req     = 3'b000;
    m_r_valid = 1'b1;
    #1;
    check("st_rvalid", s_r_valid, 3'b100);
    tick();
    m_r_valid = 1'b0;

    // Reset with transactions in flight, then spurious responses.
    do_reset();
    s_req = 3'b011;
    m_gnt = 1'b1;
    tick();
    tick();
    s_req = 3'b000;
    m_gnt = 1'b0;
    check("sp_outst_pre", outst_o, 2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("sp_outst_flushed", outst_o, 0);
    check("sp_err_pre", err_o, 0);
    m_r_valid = 1'b1;
    #1;
    check("sp_rvalid_a", s_r_valid, 3'b000);
    tick();
    check("sp_err_set", err_o, 1);
    check("sp_rvalid_b", s_r_valid, 3'b000);
    tick();
    m_r_valid = 1'b0;
    check("sp_err_hold", err_o, 1);
    check("sp_outst", outst_o, 0);
    tick();
    check("sp_err_sticky", err_o, 1);
    do_reset();
    #1;
    check("sp_err_cleared", err_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
